ultrasonic_ranger: RTL and testbench

ULTRASONIC_RANGER -- requirements
Module: ultrasonic_ranger

---
 rtl/ultrasonic_ranger.sv | 162 ++++++++++++++++
 tb/tb_ultrasonic_ranger.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ultrasonic_ranger.sv
// Ultrasonic range-finder controller: trigger pulse, echo width measurement, holdoff pacing.
// Define RANGER_CM_EN to add the dist_cm output and its centimetre prescaler.
//
// state     | meaning
// IDLE      | waiting for start or continuous
// TRIG      | driving trig for TRIG_CYCLES clocks
// WAIT_RISE | waiting for a 0->1 edge on the synchronized echo
// MEASURE   | counting echo high time
// HOLDOFF   | quiet gap after a published result
module ultrasonic_ranger #(
  parameter int TRIG_CYCLES    = 205,
  parameter int TIMEOUT_CYCLES = 800000,
  parameter int HOLDOFF_CYCLES = 1227600,
  parameter int CM_CYCLES      = 1187
) (
  input  logic        osc_clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        continuous,
  input  logic        echo,
  output logic        trig,
  output logic        busy,
  output logic        valid,
  output logic        timeout,
`ifdef RANGER_CM_EN
  output logic [9:0]  dist_cm,
`endif
  output logic [20:0] width
);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF} state_t;

  localparam logic [20:0] TRIG_LD = 21'(TRIG_CYCLES - 1);
  localparam logic [20:0] TO_LD   = 21'(TIMEOUT_CYCLES - 1);
  localparam logic [20:0] TO_W    = 21'(TIMEOUT_CYCLES);
  localparam logic [20:0] HO_LD   = 21'(HOLDOFF_CYCLES - 1);

  state_t      state;
  logic        echo_m, echo_s;
  logic        armed;
  logic [20:0] tmr;
  logic [20:0] cnt;

`ifdef RANGER_CM_EN
  localparam int PW = $clog2(CM_CYCLES + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(CM_CYCLES - 1);
  logic [PW-1:0] pre;
  logic [9:0]    cm_cnt;
`endif

  always_ff @(posedge osc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      echo_m  <= 1'b0;
      echo_s  <= 1'b0;
      armed   <= 1'b0;
      tmr     <= '0;
      cnt     <= '0;
      trig    <= 1'b0;
      busy    <= 1'b0;
      valid   <= 1'b0;
      timeout <= 1'b0;
      width   <= '0;
`ifdef RANGER_CM_EN
      pre     <= '0;
      cm_cnt  <= '0;
      dist_cm <= '0;
`endif
    end else begin
      echo_m <= echo;
      echo_s <= echo_m;
      valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (start || continuous) begin
            state <= TRIG;
            trig  <= 1'b1;
            busy  <= 1'b1;
            tmr   <= TRIG_LD;
          end
        end
        TRIG: begin
          if (tmr == '0) begin
            state <= WAIT_RISE;
            trig  <= 1'b0;
            tmr   <= TO_LD;
            armed <= 1'b0;
          end else begin
            tmr <= tmr - 21'd1;
          end
        end
        WAIT_RISE: begin
          // a rise only counts once echo_s has been seen low inside this state
          if (!echo_s) armed <= 1'b1;
          if (echo_s && armed) begin
            state <= MEASURE;
            cnt   <= 21'd1;
`ifdef RANGER_CM_EN
            pre    <= PW'(1);
            cm_cnt <= '0;
`endif
          end else if (tmr == '0) begin
            state   <= HOLDOFF;
            tmr     <= HO_LD;
            valid   <= 1'b1;
            timeout <= 1'b1;
`ifdef RANGER_CM_EN
            dist_cm <= '0;
`endif
          end else begin
            tmr <= tmr - 21'd1;
          end
        end
        MEASURE: begin
          if (!echo_s) begin
            state   <= HOLDOFF;
            tmr     <= HO_LD;
            valid   <= 1'b1;
            timeout <= 1'b0;
            width   <= cnt;
`ifdef RANGER_CM_EN
            dist_cm <= cm_cnt;
`endif
          end else if (cnt >= TO_W) begin
            state   <= HOLDOFF;
            tmr     <= HO_LD;
            valid   <= 1'b1;
            timeout <= 1'b1;
            width   <= TO_W;
`ifdef RANGER_CM_EN
            dist_cm <= '0;
`endif
          end else begin
            cnt <= cnt + 21'd1;
`ifdef RANGER_CM_EN
            if (pre == PRE_LAST) begin
              pre <= '0;
              if (cm_cnt != 10'd1023) cm_cnt <= cm_cnt + 10'd1;
            end else begin
              pre <= pre + PW'(1);
            end
`endif
          end
        end
        HOLDOFF: begin
          if (tmr == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            tmr <= tmr - 21'd1;
          end
        end
        default: begin
          state <= IDLE;
          trig  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Bench for ultrasonic_ranger with shortened timing parameters; vector table, random pulses
// and hand sequences for continuous mode and mid-measurement reset.
module tb_ultrasonic_ranger;

  localparam int TRIG = 5;
  localparam int TO   = 200;
  localparam int HO   = 50;
  localparam int CM   = 10;

  logic        osc_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic        echo = 1'b0;
  logic        trig, busy, valid, timeout;
  logic [20:0] width;
`ifdef RANGER_CM_EN
  logic [9:0]  dist_cm;
`endif

  ultrasonic_ranger #(
    .TRIG_CYCLES(TRIG), .TIMEOUT_CYCLES(TO), .HOLDOFF_CYCLES(HO), .CM_CYCLES(CM)
  ) dut (
    .osc_clk(osc_clk), .rst_n(rst_n), .start(start), .continuous(continuous), .echo(echo),
    .trig(trig), .busy(busy), .valid(valid), .timeout(timeout),
`ifdef RANGER_CM_EN
    .dist_cm(dist_cm),
`endif
    .width(width)
  );

  always #5 osc_clk = ~osc_clk;

  int cyc = 0;
  int valid_cnt = 0;
  int last_valid_cyc = 0;
  int trig_rises = 0;
  logic trig_q = 1'b0;
  int total = 0;
  int bad = 0;

  always @(posedge osc_clk) cyc <= cyc + 1;

  always @(negedge osc_clk) begin
    if (valid) begin
      valid_cnt = valid_cnt + 1;
      last_valid_cyc = cyc;
    end
    if (trig && !trig_q) trig_rises = trig_rises + 1;
    trig_q = trig;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge osc_clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural result of an echo pulse of 'high' clocks.
  function automatic void model(input int high, output bit to, output int w, output int cmv);
    if (high > TO) begin
      to = 1'b1; w = TO; cmv = 0;
    end else begin
      to = 1'b0; w = high; cmv = high / CM;
    end
  endfunction

  task automatic run_meas(input string tag, input int pre_low, input int high, input bit stuck,
                          input bit exp_to, input int exp_w, input int exp_cm);
    int v0, t0, c, wr, rise_c, exp_v, eff;
    v0 = valid_cnt;
    t0 = trig_rises;
    if (stuck) echo = 1'b1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    c = 0;
    while (!trig && c < 20) begin tick(1); c++; end
    c = 0;
    while (trig && c < 1000) begin c++; tick(1); end
    chk({tag, " trig_len"}, c, TRIG);
    wr = cyc;
    if (high > 0 && !stuck) begin
      tick(pre_low);
      echo = 1'b1;
      rise_c = cyc;
      tick(high);
      echo = 1'b0;
      eff = (high > TO) ? TO : high;
      exp_v = rise_c + eff + 3;
    end else begin
      exp_v = wr + TO;
    end
    c = 0;
    while (valid_cnt == v0 && c < TO + 400) begin tick(1); c++; end
    if (valid_cnt == v0) begin
      total++; bad++;
      $display("FAIL %s valid_wait: got none expected a pulse", tag);
    end
    chk({tag, " valid_cyc"}, last_valid_cyc, exp_v);
    chk({tag, " width"}, int'(width), exp_w);
    chk({tag, " timeout"}, int'(timeout), int'(exp_to));
`ifdef RANGER_CM_EN
    chk({tag, " dist_cm"}, int'(dist_cm), exp_cm);
`endif
    c = 0;
    while (busy && c < HO + 400) begin tick(1); c++; end
    chk({tag, " holdoff_end"}, cyc, last_valid_cyc + HO);
    echo = 1'b0;
    tick(3);
    chk({tag, " valid_count"}, valid_cnt, v0 + 1);
    chk({tag, " trig_count"}, trig_rises, t0 + 1);
  endtask

  typedef struct {
    int pre_low;
    int high;
    bit stuck;
    bit exp_to;
    int exp_w;
    int exp_cm;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int v0, t0, c, d, pl, hi, ew, ec;
    int vcyc[3];
    bit et;

    tbl[0] = '{2, 37, 1'b0, 1'b0, 37, 3};
    tbl[1] = '{3, 0, 1'b0, 1'b1, 37, 0};
    tbl[2] = '{0, 1, 1'b0, 1'b0, 1, 0};
    tbl[3] = '{0, 0, 1'b1, 1'b1, 1, 0};
    tbl[4] = '{5, 199, 1'b0, 1'b0, 199, 19};
    tbl[5] = '{4, 250, 1'b0, 1'b1, 200, 0};

    tick(3);
    chk("rst trig", int'(trig), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst valid", int'(valid), 0);
    chk("rst timeout", int'(timeout), 0);
    chk("rst width", int'(width), 0);
`ifdef RANGER_CM_EN
    chk("rst dist_cm", int'(dist_cm), 0);
`endif
    rst_n = 1'b1;
    tick(3);
    chk("idle busy", int'(busy), 0);

    for (int i = 0; i < 6; i++)
      run_meas($sformatf("vec%0d", i), tbl[i].pre_low, tbl[i].high, tbl[i].stuck,
               tbl[i].exp_to, tbl[i].exp_w, tbl[i].exp_cm);

    for (int i = 0; i < 8; i++) begin
      pl = $urandom_range(0, 15);
      hi = $urandom_range(1, 240);
      model(hi, et, ew, ec);
      run_meas($sformatf("rnd%0d_h%0d", i, hi), pl, hi, 1'b0, et, ew, ec);
    end

    // Continuous mode: three back-to-back cycles, stray starts while busy.
    v0 = valid_cnt;
    t0 = trig_rises;
    continuous = 1'b1;
    for (int k = 0; k < 3; k++) begin
      c = 0;
      while (!trig && c < HO + 100) begin tick(1); c++; end
      if (k == 2) continuous = 1'b0;
      c = 0;
      while (trig && c < 100) begin tick(1); c++; end
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(2);
      echo = 1'b1;
      tick(20 + 5 * k);
      echo = 1'b0;
      c = 0;
      while (valid_cnt == v0 + k && c < 100) begin tick(1); c++; end
      vcyc[k] = last_valid_cyc;
      chk($sformatf("cont%0d width", k), int'(width), 20 + 5 * k);
    end
    c = 0;
    while (busy && c < HO + 100) begin tick(1); c++; end
    tick(2 * HO);
    chk("cont valid_count", valid_cnt, v0 + 3);
    chk("cont trig_count", trig_rises, t0 + 3);
    chk("cont idle", int'(busy), 0);
    d = vcyc[1] - vcyc[0];
    chk("cont spacing01", int'(d >= HO), 1);
    d = vcyc[2] - vcyc[1];
    chk("cont spacing12", int'(d >= HO), 1);

    // Reset while measuring.
    v0 = valid_cnt;
    t0 = trig_rises;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    c = 0;
    while (!trig && c < 20) begin tick(1); c++; end
    c = 0;
    while (trig && c < 100) begin tick(1); c++; end
    echo = 1'b1;
    tick(10);
    rst_n = 1'b0;
    #1;
    chk("mrst trig", int'(trig), 0);
    chk("mrst busy", int'(busy), 0);
    chk("mrst valid", int'(valid), 0);
    chk("mrst timeout", int'(timeout), 0);
    chk("mrst width", int'(width), 0);
    tick(3);
    rst_n = 1'b1;
    tick(5);
    echo = 1'b0;
    tick(TO + HO + 20);
    chk("mrst no_valid", valid_cnt, v0);
    chk("mrst no_trig", trig_rises, t0 + 1);
    chk("mrst idle", int'(busy), 0);

    run_meas("post_rst", 1, 15, 1'b0, 1'b0, 15, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
